// File: rtl/reset_seq_rx.sv
// Orderly reset release for the clk125 domain: synchronizes the clock block's reset request,
// waits for it to settle low, then releases and acknowledges each downstream stage in turn.
// Optional ack watchdog is enabled by defining RST_SEQ_WDOG_EN.
module reset_seq_rx #(
  parameter int N_STAGE  = 4,
  parameter int STABLE_W = 10,
  parameter int TMO_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic               clki,
  input  logic               rsti,
  input  logic               rst_req_i,
  input  logic [N_STAGE-1:0] stage_ack_i,
  output logic [N_STAGE-1:0] rst_o,
  output logic               all_rdy_o,
  output logic               fault_o,
  output logic [2:0]         fault_stage_o
);

  if (N_STAGE < 1 || N_STAGE > 8 || SYNC_STG < 2 || STABLE_W < 1 || TMO_W < 1) begin : g_bad_param
    $error("reset_seq_rx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    HOLD, SETTLE, REL, ACKW, RUN
`ifdef RST_SEQ_WDOG_EN
    , FAULT
`endif
  } state_e;

  localparam logic [STABLE_W-1:0] SETTLE_LAST = {STABLE_W{1'b1}} - STABLE_W'(1);
  localparam logic [2:0]          IDX_LAST    = 3'(N_STAGE - 1);

  state_e               state_q, state_d;
  logic [SYNC_STG-1:0]  sync_q;
  logic                 req_s;
  logic [2:0]           idx_q, idx_d;
  logic [STABLE_W-1:0]  scnt_q, scnt_d;
  logic [N_STAGE-1:0]   rst_q, rst_d;
  logic                 rdy_q, rdy_d;
  logic [7:0]           ack_pad;
`ifdef RST_SEQ_WDOG_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);
  logic [TMO_W-1:0]     tcnt_q, tcnt_d;
  logic                 fault_q, fault_d;
  logic [2:0]           fstage_q, fstage_d;
`endif

  // Preset to "request asserted" so a fresh power-up never looks like a settled-low request.
  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STG-2:0], rst_req_i};
  end

  assign req_s   = sync_q[SYNC_STG-1];
  assign ack_pad = 8'(stage_ack_i);

  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) begin
      state_q  <= HOLD;
      idx_q    <= '0;
      scnt_q   <= '0;
      rst_q    <= '1;
      rdy_q    <= 1'b0;
`ifdef RST_SEQ_WDOG_EN
      tcnt_q   <= '0;
      fault_q  <= 1'b0;
      fstage_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      rst_q    <= rst_d;
      rdy_q    <= rdy_d;
`ifdef RST_SEQ_WDOG_EN
      tcnt_q   <= tcnt_d;
      fault_q  <= fault_d;
      fstage_q <= fstage_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    rst_d    = rst_q;
    rdy_d    = rdy_q;
`ifdef RST_SEQ_WDOG_EN
    tcnt_d   = tcnt_q;
    fault_d  = fault_q;
    fstage_d = fstage_q;
`endif
    unique case (state_q)
      HOLD: begin
        rst_d = '1;
        rdy_d = 1'b0;
        if (!req_s) begin
          state_d = SETTLE;
          scnt_d  = '0;
        end
      end
      SETTLE: begin
        scnt_d = scnt_q + STABLE_W'(1);
        if (scnt_q == SETTLE_LAST) begin
          state_d = REL;
          idx_d   = '0;
        end
      end
      REL: begin
        for (int i = 0; i < N_STAGE; i++) begin
          if (idx_q == 3'(i)) rst_d[i] = 1'b0;
        end
        state_d = ACKW;
`ifdef RST_SEQ_WDOG_EN
        tcnt_d  = '0;
`endif
      end
      ACKW: begin
        if (ack_pad[idx_q]) begin
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            rdy_d   = 1'b1;
          end else begin
            state_d = REL;
            idx_d   = idx_q + 3'd1;
          end
        end
`ifdef RST_SEQ_WDOG_EN
        else begin
          tcnt_d = tcnt_q + TMO_W'(1);
          if (tcnt_q == TMO_LAST) begin
            state_d  = FAULT;
            rst_d    = '1;
            fault_d  = 1'b1;
            fstage_d = idx_q;
          end
        end
`endif
      end
      default: ;
    endcase

    // A fresh request outranks any ack or timeout decided above.
    if (req_s && state_q != HOLD) begin
      state_d  = HOLD;
      rst_d    = '1;
      rdy_d    = 1'b0;
`ifdef RST_SEQ_WDOG_EN
      fault_d  = 1'b0;
      fstage_d = '0;
`endif
    end
  end

  assign rst_o     = rst_q;
  assign all_rdy_o = rdy_q;
`ifdef RST_SEQ_WDOG_EN
  assign fault_o       = fault_q;
  assign fault_stage_o = fstage_q;
`else
  assign fault_o       = 1'b0;
  assign fault_stage_o = 3'd0;
`endif

endmodule

// File: tb/tb_reset_seq_rx.sv
// Self-checking bench for reset_seq_rx: a count-based model of the release sequence is compared
// every cycle, and directed scenarios pin exact cycle positions with literal expectations.
module tb_reset_seq_rx;

  localparam int N  = 4;
  localparam int SW = 4;
  localparam int TW = 6;
  localparam int SS = 2;
  localparam int SETTLE_CYC = (1 << SW) - 1;
  localparam int TMO_CYC    = (1 << TW) - 1;

  localparam int P_HOLD = 0, P_SETTLE = 1, P_REL = 2, P_WAIT = 3, P_RUN = 4, P_FAULT = 5;

  logic         clki = 1'b0;
  logic         rsti = 1'b0;
  logic         rst_req_i = 1'b1;
  logic [N-1:0] stage_ack_i = '1;
  logic [N-1:0] rst_o;
  logic         all_rdy_o;
  logic         fault_o;
  logic [2:0]   fault_stage_o;

  int errors = 0;
  int checks = 0;

  reset_seq_rx #(.N_STAGE(N), .STABLE_W(SW), .TMO_W(TW), .SYNC_STG(SS)) dut (
    .clki(clki), .rsti(rsti), .rst_req_i(rst_req_i), .stage_ack_i(stage_ack_i),
    .rst_o(rst_o), .all_rdy_o(all_rdy_o), .fault_o(fault_o), .fault_stage_o(fault_stage_o)
  );

  always #4 clki = ~clki;

  // Model: the outputs follow from how many stages are released, plus the current phase.
  int       mPhase, mSettle, mRel, mTmo, mFault, mFStage;
  logic [SS-1:0] mPipe;
  logic     mReqS;

  always @(posedge clki or negedge rsti) begin
    if (!rsti) begin
      mPipe = '1; mPhase = P_HOLD; mSettle = 0; mRel = 0; mTmo = 0; mFault = 0; mFStage = 0;
    end else begin
      mReqS = mPipe[SS-1];
      mPipe = {mPipe[SS-2:0], rst_req_i};
      if (mReqS && mPhase != P_HOLD) begin
        mPhase = P_HOLD; mRel = 0; mFault = 0; mFStage = 0;
      end else begin
        case (mPhase)
          P_HOLD:   if (!mReqS) begin mPhase = P_SETTLE; mSettle = 0; end
          P_SETTLE: begin
            mSettle++;
            if (mSettle == SETTLE_CYC) mPhase = P_REL;
          end
          P_REL:    begin mRel++; mPhase = P_WAIT; mTmo = 0; end
          P_WAIT: begin
            if (stage_ack_i[mRel-1]) mPhase = (mRel == N) ? P_RUN : P_REL;
`ifdef RST_SEQ_WDOG_EN
            else begin
              mTmo++;
              if (mTmo == TMO_CYC) begin
                mPhase = P_FAULT; mFault = 1; mFStage = mRel - 1; mRel = 0;
              end
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clki) begin
    if (rsti) begin
      checkOutput("model rst_o", int'(rst_o), ((1 << N) - 1) & ~((1 << mRel) - 1));
      checkOutput("model all_rdy_o", int'(all_rdy_o), (mPhase == P_RUN) ? 1 : 0);
      checkOutput("model fault_o", int'(fault_o), mFault);
      checkOutput("model fault_stage_o", int'(fault_stage_o), mFStage);
    end
  end

  task automatic applyStimulus(input logic req, input logic [N-1:0] ack);
    rst_req_i   = req;
    stage_ack_i = ack;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clki);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    // Power-up with the request asserted; nothing may release for a long time.
    applyStimulus(1'b1, 4'hF);
    waitCycles(3);
    checkOutput("reset rst_o", int'(rst_o), 'hF);
    checkOutput("reset all_rdy_o", int'(all_rdy_o), 0);
    checkOutput("reset fault_o", int'(fault_o), 0);
    rsti = 1'b1;
    waitCycles(1000);
    checkOutput("hold rst_o", int'(rst_o), 'hF);

    // Clean bring-up with acks already high: E at 19, then 2-cycle spacing.
    applyStimulus(1'b0, 4'hF);
    waitCycles(18); checkOutput("seq pre-release", int'(rst_o), 'hF);
    waitCycles(1);  checkOutput("seq stage0", int'(rst_o), 'hE);
    waitCycles(2);  checkOutput("seq stage1", int'(rst_o), 'hC);
    waitCycles(2);  checkOutput("seq stage2", int'(rst_o), 'h8);
    waitCycles(2);  checkOutput("seq stage3", int'(rst_o), 'h0);
    checkOutput("seq rdy before run", int'(all_rdy_o), 0);
    waitCycles(1);  checkOutput("seq rdy in run", int'(all_rdy_o), 1);

    // Request from RUN: reset returns SYNC_STG+1 cycles later.
    applyStimulus(1'b1, 4'h0);
    waitCycles(SS); checkOutput("req rise early", int'(rst_o), 'h0);
    waitCycles(1);
    checkOutput("req rise rst_o", int'(rst_o), 'hF);
    checkOutput("req rise rdy", int'(all_rdy_o), 0);
    waitCycles(4);

    // One-cycle request glitch during settle restarts the settle period.
    applyStimulus(1'b0, 4'hF);
    waitCycles(11); applyStimulus(1'b1, 4'hF);
    waitCycles(1);  applyStimulus(1'b0, 4'hF);
    waitCycles(7);  checkOutput("glitch no early release", int'(rst_o), 'hF);
    waitCycles(11); checkOutput("glitch still held", int'(rst_o), 'hF);
    waitCycles(1);  checkOutput("glitch first release", int'(rst_o), 'hE);
    waitCycles(7);  checkOutput("glitch rdy", int'(all_rdy_o), 1);

    // Stage 2 never acknowledges; other acks stay high and must be ignored.
    applyStimulus(1'b1, 4'hF);
    waitCycles(5);
    applyStimulus(1'b0, 4'b1011);
    waitCycles(23); checkOutput("stall rst_o", int'(rst_o), 'h8);
`ifdef RST_SEQ_WDOG_EN
    waitCycles(62); checkOutput("wdog not yet", int'(fault_o), 0);
    waitCycles(1);
    checkOutput("wdog fault_o", int'(fault_o), 1);
    checkOutput("wdog fault_stage_o", int'(fault_stage_o), 2);
    checkOutput("wdog rst_o", int'(rst_o), 'hF);
    applyStimulus(1'b1, 4'b1011);
    waitCycles(SS + 1);
    checkOutput("wdog cleared", int'(fault_o), 0);
`else
    waitCycles(10000);
    checkOutput("stall long rst_o", int'(rst_o), 'h8);
    checkOutput("stall long fault_o", int'(fault_o), 0);
    checkOutput("stall long rdy", int'(all_rdy_o), 0);
    applyStimulus(1'b1, 4'b1011);
    waitCycles(SS + 1);
`endif
    checkOutput("stall abort rst_o", int'(rst_o), 'hF);

    // Asynchronous reset while waiting on stage 1.
    waitCycles(2);
    applyStimulus(1'b0, 4'b1101);
    waitCycles(25); checkOutput("async pre rst_o", int'(rst_o), 'hC);
    #2 rsti = 1'b0;
    #1;
    checkOutput("async rst_o", int'(rst_o), 'hF);
    checkOutput("async all_rdy_o", int'(all_rdy_o), 0);
    checkOutput("async fault_o", int'(fault_o), 0);
    checkOutput("async fault_stage_o", int'(fault_stage_o), 0);
    applyStimulus(1'b1, 4'hF);
    @(negedge clki);
    rsti = 1'b1;
    waitCycles(5);
    checkOutput("after async rst_o", int'(rst_o), 'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
